conv_index_seq: RTL and testbench

- Sequencing FSM for the 1-D convolution core: y[i] = sum over k of x[k]*h[i-k].
- Walks the output index i from 0 to Nx+Nh-2, and for each i the valid k range.
- Issues read addresses to the X and H memories, clear/enable strobes to the MAC, and one write strobe per output to the Y memory.
- Sits between the host start/config registers and the datapath; consumes the y-index incrementer's result as its next-i value.

---
 rtl/conv_pkg.sv | 23 ++
 rtl/conv_k_bounds.sv | 31 +++
 rtl/conv_y_inc.sv | 11 +
 rtl/conv_index_seq.sv | 145 ++++++++++++++
 tb/tb_conv_index_seq.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared types, widths and size check for the convolution sequencer
package conv_pkg;

  localparam int MAX_LEN = 32;
  localparam int AW_IN   = 5;
  localparam int AW_OUT  = 6;
  localparam int SW      = 6;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CALC  = 3'd1,
    RUN   = 3'd2,
    FLUSH = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5
  } state_t;

  // A length is usable when it is 1..MAX_LEN
  function automatic logic size_ok(input logic [SW-1:0] s);
    return (s != '0) && (s <= SW'(MAX_LEN));
  endfunction

endpackage

// File: rtl/conv_k_bounds.sv
// rtl/conv_k_bounds.sv - valid k range and final output index for a given i
module conv_k_bounds
  import conv_pkg::*;
(
  input  logic [AW_OUT-1:0] i,
  input  logic [SW-1:0]     nx,
  input  logic [SW-1:0]     nh,
  output logic [AW_IN-1:0]  kmin,
  output logic [AW_IN-1:0]  kmax,
  output logic [AW_OUT-1:0] last
);

  logic [SW-1:0]     nx_m1;
  logic [SW-1:0]     nh_m1;
  logic [AW_OUT-1:0] lo;
  logic [AW_OUT-1:0] hi;
  logic [AW_OUT:0]   sum;

  // Clip k so that both k and i-k stay inside their sequences; last uses one spare bit so 32+32 cannot wrap
  always_comb begin
    nx_m1 = nx - SW'(1);
    nh_m1 = nh - SW'(1);
    lo    = (i > nh_m1) ? (i - nh_m1) : '0;
    hi    = (i < nx_m1) ? i : nx_m1;
    sum   = (AW_OUT+1)'(nx) + (AW_OUT+1)'(nh) - (AW_OUT+1)'(2);
    kmin  = AW_IN'(lo);
    kmax  = AW_IN'(hi);
    last  = AW_OUT'(sum);
  end

endmodule

// File: rtl/conv_y_inc.sv
// rtl/conv_y_inc.sv - 6-bit y-index incrementer
module conv_y_inc
  import conv_pkg::*;
(
  input  logic [AW_OUT-1:0] a,
  output logic [AW_OUT-1:0] y
);

  assign y = a + AW_OUT'(1);

endmodule

// File: rtl/conv_index_seq.sv
// rtl/conv_index_seq.sv - output/k index sequencer driving X/H reads, MAC strobes and Y writes
module conv_index_seq
  import conv_pkg::*;
(
  input  logic              clk,
  input  logic              rst_a,
  input  logic              start,
  input  logic [SW-1:0]     size_x,
  input  logic [SW-1:0]     size_h,
  output logic [AW_IN-1:0]  addr_x,
  output logic [AW_IN-1:0]  addr_h,
  output logic              rd_en,
  output logic              acc_clr,
  output logic              mac_en,
  output logic [AW_OUT-1:0] addr_y,
  output logic              wr_y,
  output logic              busy,
  output logic              done,
  output logic              size_err
);

  state_t            state_q, state_d;
  logic [AW_OUT-1:0] i_q, i_d, i_inc, last, addr_y_q;
  logic [AW_IN-1:0]  k_q, k_d, kmin, kmax;
  logic [SW-1:0]     nx_q, nx_d, nh_q, nh_d;
  logic              mac_en_q, size_err_q, size_err_d;

  conv_k_bounds u_bounds (
    .i    (i_q),
    .nx   (nx_q),
    .nh   (nh_q),
    .kmin (kmin),
    .kmax (kmax),
    .last (last)
  );

  conv_y_inc u_y_inc (
    .a (i_q),
    .y (i_inc)
  );

  // State register; reset aborts any run on the spot
  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Index, latched sizes, held Y address and the one-cycle-delayed strobes
  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      i_q        <= '0;
      k_q        <= '0;
      nx_q       <= '0;
      nh_q       <= '0;
      addr_y_q   <= '0;
      mac_en_q   <= 1'b0;
      size_err_q <= 1'b0;
    end else begin
      i_q        <= i_d;
      k_q        <= k_d;
      nx_q       <= nx_d;
      nh_q       <= nh_d;
      mac_en_q   <= rd_en;
      size_err_q <= size_err_d;
      if (state_q == WRITE) begin
        addr_y_q <= i_q;
      end
    end
  end

  // Next-state and Moore outputs; addresses read 0 and strobes stay low outside their state
  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    k_d        = k_q;
    nx_d       = nx_q;
    nh_d       = nh_q;
    size_err_d = 1'b0;
    addr_x     = '0;
    addr_h     = '0;
    addr_y     = addr_y_q;
    rd_en      = 1'b0;
    acc_clr    = 1'b0;
    wr_y       = 1'b0;
    done       = 1'b0;
    busy       = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (start) begin
          if (size_ok(size_x) && size_ok(size_h)) begin
            nx_d    = size_x;
            nh_d    = size_h;
            i_d     = '0;
            k_d     = '0;
            state_d = CALC;
          end else begin
            size_err_d = 1'b1;
          end
        end
      end
      CALC: begin
        acc_clr = 1'b1;
        k_d     = kmin;
        state_d = RUN;
      end
      RUN: begin
        rd_en  = 1'b1;
        addr_x = k_q;
        addr_h = AW_IN'(i_q - AW_OUT'(k_q));
        if (k_q == kmax) begin
          state_d = FLUSH;
        end else begin
          k_d = k_q + AW_IN'(1);
        end
      end
      FLUSH: begin
        state_d = WRITE;
      end
      WRITE: begin
        wr_y   = 1'b1;
        addr_y = i_q;
        if (i_q == last) begin
          state_d = DONE;
        end else begin
          i_d     = i_inc;
          state_d = CALC;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign mac_en   = mac_en_q;
  assign size_err = size_err_q;

endmodule

// File: tb/tb_conv_index_seq.sv
// tb/tb_conv_index_seq.sv - randomized and directed self-checking bench for conv_index_seq
module tb_conv_index_seq;

  logic       clk = 1'b0;
  logic       rst_a = 1'b0;
  logic       start = 1'b0;
  logic [5:0] size_x = '0;
  logic [5:0] size_h = '0;
  logic [4:0] addr_x, addr_h;
  logic       rd_en, acc_clr, mac_en;
  logic [5:0] addr_y;
  logic       wr_y, busy, done, size_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  conv_index_seq dut (
    .clk      (clk),
    .rst_a    (rst_a),
    .start    (start),
    .size_x   (size_x),
    .size_h   (size_h),
    .addr_x   (addr_x),
    .addr_h   (addr_h),
    .rd_en    (rd_en),
    .acc_clr  (acc_clr),
    .mac_en   (mac_en),
    .addr_y   (addr_y),
    .wr_y     (wr_y),
    .busy     (busy),
    .done     (done),
    .size_err (size_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: every (k, i-k) pair with both indices inside their sequences, one write per i
  int exp_x[$], exp_h[$], exp_y[$];
  int exp_cyc;
  function automatic void build(input int nx, input int nh);
    exp_x.delete(); exp_h.delete(); exp_y.delete();
    for (int i = 0; i <= nx + nh - 2; i++) begin
      for (int k = 0; k < nx; k++) begin
        if (i - k >= 0 && i - k < nh) begin
          exp_x.push_back(k);
          exp_h.push_back(i - k);
        end
      end
      exp_y.push_back(i);
    end
    exp_cyc = 3 * (nx + nh - 1) + exp_x.size() + 1;
  endfunction

  int got_x[$], got_h[$], got_y[$];
  int done_cyc;

  task automatic run_case(input int nx, input int nh, input bit poke, input string tag);
    logic prev_rd = 1'b0;
    bit   seen = 1'b0;
    int   nclr = 0, nmac = 0, bad_addr = 0, bad_mac = 0, bad_busy = 0, bad_err = 0;
    int   pair_bad = 0, y_bad = 0;
    build(nx, nh);
    got_x.delete(); got_h.delete(); got_y.delete();
    done_cyc = -1;
    @(negedge clk);
    size_x = 6'(nx);
    size_h = 6'(nh);
    start  = 1'b1;
    for (int c = 1; c <= 5000 && !seen; c++) begin
      @(negedge clk);
      if (rd_en) begin
        got_x.push_back(int'(addr_x));
        got_h.push_back(int'(addr_h));
      end else if (addr_x != 0 || addr_h != 0) begin
        bad_addr++;
      end
      if (wr_y) got_y.push_back(int'(addr_y));
      if (mac_en !== prev_rd) bad_mac++;
      if (mac_en && (acc_clr || wr_y)) bad_mac++;
      if (mac_en) nmac++;
      prev_rd = rd_en;
      if (acc_clr) nclr++;
      if (!busy) bad_busy++;
      if (size_err) bad_err++;
      if (done) begin
        seen = 1'b1;
        done_cyc = c;
      end else begin
        start = poke ? 1'($urandom_range(0, 1)) : 1'b0;
        if (poke) begin
          size_x = 6'($urandom);
          size_h = 6'($urandom);
        end
      end
    end
    // On the done cycle a poked run requests again; it must be ignored
    start = poke;
    @(negedge clk);
    check({tag, "_busy_after_done"}, busy, 0);
    start = 1'b0;
    for (int n = 0; n < exp_x.size() && n < got_x.size(); n++) begin
      if (got_x[n] != exp_x[n] || got_h[n] != exp_h[n]) pair_bad++;
    end
    for (int n = 0; n < exp_y.size() && n < got_y.size(); n++) begin
      if (got_y[n] != exp_y[n]) y_bad++;
    end
    check({tag, "_done_cycle"}, done_cyc, exp_cyc);
    check({tag, "_reads"}, got_x.size(), exp_x.size());
    check({tag, "_read_pair_errs"}, pair_bad, 0);
    check({tag, "_writes"}, got_y.size(), exp_y.size());
    check({tag, "_write_addr_errs"}, y_bad, 0);
    check({tag, "_acc_clr"}, nclr, exp_y.size());
    check({tag, "_mac_en"}, nmac, exp_x.size());
    check({tag, "_mac_timing_errs"}, bad_mac, 0);
    check({tag, "_idle_addr_errs"}, bad_addr, 0);
    check({tag, "_busy_gaps"}, bad_busy, 0);
    check({tag, "_spurious_size_err"}, bad_err, 0);
    check({tag, "_addr_y_held"}, addr_y, nx + nh - 2);
  endtask

  task automatic bad_start(input int nx, input int nh, input string tag);
    int pulses = 0, busies = 0;
    @(negedge clk);
    size_x = 6'(nx);
    size_h = 6'(nh);
    start  = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (size_err) pulses++;
      if (busy) busies++;
    end
    check({tag, "_size_err_pulses"}, pulses, 1);
    check({tag, "_busy"}, busies, 0);
  endtask

  initial begin
    bit saw_rd = 1'b0;
    int stray = 0;

    #12;
    check("reset_outputs", {addr_x, addr_h, rd_en, acc_clr, mac_en, addr_y, wr_y, busy, done, size_err}, 0);
    @(negedge clk);
    rst_a = 1'b1;
    @(negedge clk);
    check("idle_after_reset", {busy, done, size_err}, 0);

    run_case(1, 1, 1'b0, "n1x1");
    run_case(3, 2, 1'b0, "n3x2");
    check("n3x2_done_at_19", done_cyc, 19);
    run_case(32, 32, 1'b0, "n32x32");
    check("n32x32_run_cycles", got_x.size(), 1024);
    check("n32x32_last_write", got_y[$], 62);

    bad_start(0, 5, "size_x0");
    bad_start(4, 33, "size_h33");
    bad_start(63, 7, "size_x63");
    run_case(5, 4, 1'b0, "after_err");

    run_case(7, 9, 1'b1, "poked");

    for (int n = 0; n < 6; n++) begin
      run_case(int'($urandom_range(1, 32)), int'($urandom_range(1, 32)), n[0], $sformatf("rand%0d", n));
    end

    // Abort during RUN with an asynchronous reset pulse between clock edges
    @(negedge clk);
    size_x = 6'd8;
    size_h = 6'd5;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 20 && !saw_rd; c++) begin
      @(negedge clk);
      if (rd_en) saw_rd = 1'b1;
    end
    check("abort_reached_run", saw_rd, 1);
    #2 rst_a = 1'b0;
    #1;
    check("abort_outputs_zero", {addr_x, addr_h, rd_en, acc_clr, mac_en, addr_y, wr_y, busy, done, size_err}, 0);
    @(negedge clk);
    rst_a = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done || busy || wr_y || rd_en) stray++;
    end
    check("abort_no_activity", stray, 0);
    run_case(4, 3, 1'b0, "after_abort");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
